// File: rtl/fetch_pc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pc_if                                                  |
// | Description : Control, training and fetch-address bundle of the IF-stage   |
// |               PC unit.                                                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface fetch_pc_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             upd_valid;
    logic [WIDTH-1:0] upd_pc;
    logic             upd_taken;
    logic [WIDTH-1:0] upd_target;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    modport master (
        output stall, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  pc, pc_valid, pred_taken, pred_target
    );

    modport slave (
        input  stall, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output pc, pc_valid, pred_taken, pred_target
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pc_unit                                                |
// | Description : DLX IF-stage fetch PC with optional direct-mapped BTB        |
// |               (enabled by defining FETCH_PC_BTB_EN).                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fetch_pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h00400020,
    parameter int               BTB_DEPTH  = 8,
    parameter int               INSN_BYTES = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_pc_if.slave     bus
);

    localparam logic [WIDTH-1:0] c_INC = WIDTH'(INSN_BYTES);

    logic [WIDTH-1:0] r_pc;
    logic             r_started;
    logic             r_pc_valid;
    logic             w_pred_taken;
    logic [WIDTH-1:0] w_pred_target;

`ifdef FETCH_PC_BTB_EN
    localparam int c_IDX  = $clog2(BTB_DEPTH);
    localparam int c_TAGW = WIDTH - c_IDX - 2;

    logic             r_btb_valid  [BTB_DEPTH];
    logic [c_TAGW-1:0] r_btb_tag   [BTB_DEPTH];
    logic [WIDTH-1:0] r_btb_target [BTB_DEPTH];
    logic [1:0]       r_btb_ctr    [BTB_DEPTH];

    logic [c_IDX-1:0]  w_rd_idx;
    logic [c_TAGW-1:0] w_rd_tag;
    logic [c_IDX-1:0]  w_up_idx;
    logic [c_TAGW-1:0] w_up_tag;
    logic              w_rd_hit;
    logic              w_up_hit;
    logic              w_unused_low_bits;

    assign w_rd_idx = r_pc[c_IDX+1:2];
    assign w_rd_tag = r_pc[WIDTH-1:c_IDX+2];
    assign w_up_idx = bus.upd_pc[c_IDX+1:2];
    assign w_up_tag = bus.upd_pc[WIDTH-1:c_IDX+2];

    assign w_rd_hit      = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
    assign w_up_hit      = r_btb_valid[w_up_idx] && (r_btb_tag[w_up_idx] == w_up_tag);
    assign w_pred_taken  = w_rd_hit && r_btb_ctr[w_rd_idx][1];
    assign w_pred_target = w_pred_taken ? r_btb_target[w_rd_idx] : '0;

    // Byte-offset bits never take part in indexing or tagging.
    assign w_unused_low_bits = ^{r_pc[1:0], bus.upd_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
                r_btb_ctr[i]    <= 2'd0;
            end
        end else if (bus.upd_valid) begin
            if (w_up_hit) begin
                if (bus.upd_taken) begin
                    r_btb_ctr[w_up_idx]    <= (r_btb_ctr[w_up_idx] == 2'd3) ? 2'd3 : r_btb_ctr[w_up_idx] + 2'd1;
                    r_btb_target[w_up_idx] <= bus.upd_target;
                end else begin
                    r_btb_ctr[w_up_idx]    <= (r_btb_ctr[w_up_idx] == 2'd0) ? 2'd0 : r_btb_ctr[w_up_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                // Taken miss evicts whatever aliases into this slot.
                r_btb_valid[w_up_idx]  <= 1'b1;
                r_btb_tag[w_up_idx]    <= w_up_tag;
                r_btb_target[w_up_idx] <= bus.upd_target;
                r_btb_ctr[w_up_idx]    <= 2'd2;
            end
        end
    end
`else
    logic w_unused_btb;

    assign w_pred_taken  = 1'b0;
    assign w_pred_target = '0;
    assign w_unused_btb  = ^{bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target, 1'(BTB_DEPTH)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_started  <= 1'b0;
            r_pc_valid <= 1'b0;
        end else begin
            r_started  <= 1'b1;
            r_pc_valid <= r_started;
            if (bus.redirect) begin
                r_pc <= bus.redirect_pc;
            end else if (!bus.stall) begin
                r_pc <= w_pred_taken ? w_pred_target : r_pc + c_INC;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_valid    = r_pc_valid;
    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_target = w_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_pc_unit                                             |
// | Description : Directed scoreboard bench for fetch_pc_unit; expectations    |
// |               follow FETCH_PC_BTB_EN.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_fetch_pc_unit;

`ifdef FETCH_PC_BTB_EN
    localparam bit c_BTB = 1'b1;
`else
    localparam bit c_BTB = 1'b0;
`endif
    localparam logic [31:0] c_Z = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        pt;
        logic [31:0] tg;
        int          id;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    exp_t sb[$];

    fetch_pc_if #(.WIDTH(32)) bus ();

    fetch_pc_unit #(
        .WIDTH      (32),
        .RESET_PC   (32'h00400020),
        .BTB_DEPTH  (8),
        .INSN_BYTES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare the post-edge state against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.pc_valid !== e.vld || bus.pred_taken !== e.pt || bus.pred_target !== e.tg) begin
                errors++;
                $display("FAIL step%0d: got pc=%h vld=%b pt=%b tg=%h, expected pc=%h vld=%b pt=%b tg=%h",
                         e.id, bus.pc, bus.pc_valid, bus.pred_taken, bus.pred_target, e.pc, e.vld, e.pt, e.tg);
            end
        end
    end

    task automatic step(input logic rs, input logic st, input logic rd, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic [31:0] epc, input logic ev, input logic ept, input logic [31:0] etg);
        exp_t e;
        reset           = rs;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.upd_valid   = uv;
        bus.upd_pc      = upc;
        bus.upd_taken   = ut;
        bus.upd_target  = utg;
        @(posedge clk);
        e.pc = epc; e.vld = ev; e.pt = ept; e.tg = etg; e.id = step_id;
        sb.push_back(e);
        step_id++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, release, sequential fetch, pc_valid latency
        step(1,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400020,0,0,c_Z);
        step(1,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400020,0,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400024,0,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400028,1,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h0040002C,1,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400030,1,0,c_Z);
        // Stall hold, then redirect beats stall
        for (int i = 0; i < 3; i++)
            step(0,1,0,c_Z, 0,c_Z,0,c_Z, 32'h00400030,1,0,c_Z);
        step(0,1,1,32'h00400100, 0,c_Z,0,c_Z, 32'h00400100,1,0,c_Z);
        // Allocate 0x00400040 -> 0x00400080 and fetch through it
        step(0,0,1,32'h00400038, 1,32'h00400040,1,32'h00400080, 32'h00400038,1,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h0040003C,1,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400040,1,c_BTB,c_BTB ? 32'h00400080 : c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, c_BTB ? 32'h00400080 : 32'h00400044,1,0,c_Z);
        // Stall overrides a taken prediction
        step(0,0,1,32'h00400040, 0,c_Z,0,c_Z, 32'h00400040,1,c_BTB,c_BTB ? 32'h00400080 : c_Z);
        step(0,1,0,c_Z, 0,c_Z,0,c_Z, 32'h00400040,1,c_BTB,c_BTB ? 32'h00400080 : c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, c_BTB ? 32'h00400080 : 32'h00400044,1,0,c_Z);
        // Counter 2->1->0, then 0->1 stays not-taken
        step(0,0,1,32'h00400040, 1,32'h00400040,0,c_Z, 32'h00400040,1,0,c_Z);
        step(0,1,0,c_Z, 1,32'h00400040,0,c_Z, 32'h00400040,1,0,c_Z);
        step(0,1,0,c_Z, 1,32'h00400040,1,32'h00400080, 32'h00400040,1,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400044,1,0,c_Z);
        // 1->2 taken again with a fresh target
        step(0,0,1,32'h00400040, 1,32'h00400040,1,32'h00400090, 32'h00400040,1,c_BTB,c_BTB ? 32'h00400090 : c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, c_BTB ? 32'h00400090 : 32'h00400044,1,0,c_Z);
        // Alias 0x00400060 evicts 0x00400040
        step(0,0,1,32'h00400040, 1,32'h00400060,1,32'h00400100, 32'h00400040,1,0,c_Z);
        step(0,0,1,32'h00400060, 0,c_Z,0,c_Z, 32'h00400060,1,c_BTB,c_BTB ? 32'h00400100 : c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, c_BTB ? 32'h00400100 : 32'h00400064,1,0,c_Z);
        // Wrap past all-ones
        step(0,0,1,32'hFFFFFFFC, 0,c_Z,0,c_Z, 32'hFFFFFFFC,1,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00000000,1,0,c_Z);
        // Mid-run reset clears BTB and aborts concurrent training
        step(1,0,0,c_Z, 1,32'h00400100,1,32'h00400200, 32'h00400020,0,0,c_Z);
        step(0,0,0,c_Z, 0,c_Z,0,c_Z, 32'h00400024,0,0,c_Z);
        step(0,0,1,32'h00400060, 0,c_Z,0,c_Z, 32'h00400060,1,0,c_Z);
        step(0,0,1,32'h00400100, 0,c_Z,0,c_Z, 32'h00400100,1,0,c_Z);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised fetch program-counter unit for the DLX pipeline IF stage. Holds the current fetch PC driven to instruction SRAM and selects the next PC from reset vector, EX-stage redirect, ID-stage stall hold, a direct-mapped branch target buffer (BTB) prediction, or sequential increment. The EX stage trains the BTB with resolved branch outcomes.

## Interface
Parameters:
- WIDTH, 32, PC width in bits
- RESET_PC, 32'h00400020, fetch address after reset
- BTB_DEPTH, 8, BTB entries; power of two, 2..64
- INSN_BYTES, 4, sequential increment; power of two

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  ID-stage hold (kill_next_instruction); PC holds
- redirect  input  1  EX-stage mispredict/branch correction
- redirect_pc  input  WIDTH  corrected fetch address
- upd_valid  input  1  resolved branch report from EX
- upd_pc  input  WIDTH  address of resolved branch
- upd_taken  input  1  resolved direction
- upd_target  input  WIDTH  resolved taken target
- pc  output  WIDTH  current fetch address to SRAM
- pc_valid  output  1  low during reset cycle and the first cycle after, then high
- pred_taken  output  1  BTB predicts current pc taken (combinational on pc)
- pred_target  output  WIDTH  predicted target for current pc (zero when pred_taken=0)

## Operation
- IDX = log2(BTB_DEPTH); index = pc[IDX+1:2]; tag = pc[WIDTH-1:IDX+2].
- Entry: valid, tag, target (WIDTH), 2-bit saturating counter ctr.
- Lookup hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = entry target when pred_taken.
- Next-PC priority (highest first): reset -> RESET_PC; redirect -> redirect_pc; stall -> pc; pred_taken -> pred_target; else pc + INSN_BYTES, modulo 2^WIDTH (wrap from all-ones region to 0, no flag).
- redirect_pc/pred_target used verbatim; no alignment forcing.
- Training on upd_valid, indexed/tagged from upd_pc:
  - hit: ctr increments (taken) or decrements (not taken), saturating at 3/0; on taken, target overwritten with upd_target.
  - miss, taken: allocate (overwrite any occupant): valid=1, new tag, target=upd_target, ctr=2.
  - miss, not taken: no change.
- Training is independent of stall and redirect; performed whenever upd_valid=1 and reset=0.

## Timing
- Reset (sampled at rising edge): pc=RESET_PC, all valid=0, all ctr=0, pc_valid=0; pred_taken=0, pred_target=0 follow since valid=0.
- pc_valid rises one cycle after first non-reset edge; reset asserted mid-operation returns everything to reset values at that edge, aborting any pending training.
- pc changes one cycle after the selecting inputs are sampled; prediction for pc is visible in the same cycle as pc.
- Update-then-lookup: write takes effect at the edge; a lookup of the same index in the update cycle sees old contents, next cycle sees new.
- redirect && stall: redirect wins. stall && pred_taken: stall wins, pc held, prediction re-evaluated next cycle.
- No handshake back-pressure; upd_valid is single-cycle, one report per cycle.

## Configuration
- FETCH_PC_BTB_EN defined: BTB present as above.
- Undefined: no BTB storage; pred_taken=0, pred_target=0 always; upd_* ignored; next-PC is reset/redirect/stall/pc+INSN_BYTES only.

## Test plan
- Reset 2 cycles then release, no stall -> pc=0x00400020, then 0x00400024, 0x00400028; pc_valid 0 until second cycle after release.
- stall=1 for 3 cycles at pc=0x00400030 -> pc stays 0x00400030; with redirect=1, redirect_pc=0x00400100 also high -> next pc=0x00400100.
- upd_valid, upd_pc=0x00400040, upd_taken=1, upd_target=0x00400080; later fetch reaches 0x00400040 -> pred_taken=1, pred_target=0x00400080, next pc=0x00400080.
- Two not-taken updates for 0x00400040 after allocation (ctr 2->1->0) -> pred_taken=0, next pc=0x00400044; one taken update -> ctr=1, still not taken.
- Aliasing (DEPTH=8): allocate 0x00400040 then taken update 0x00400060 (same index) -> 0x00400040 misses, 0x00400060 hits.
- WIDTH=32, redirect to 0xFFFFFFFC -> next pc=0x00000000; with macro undefined, repeat BTB test -> pred_taken stays 0.
